// File: rtl/player_pkg.sv
// Playfield constants and bullet state encoding shared by the ship, bullet
// and collision blocks.
package player_pkg;

  localparam int COORD_W = 10;

  localparam logic [COORD_W-1:0] SCREEN_TOP = 10'd32;
  localparam logic [COORD_W-1:0] SHIP_TOP_Y = 10'd441;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b001,
    ST_FLYING   = 3'b010,
    ST_COOLDOWN = 3'b100
  } bullet_state_t;

  // Midpoint of the ship; the 11-bit sum keeps the carry of wide ships.
  function automatic logic [COORD_W-1:0] centre_x(input logic [COORD_W-1:0] left,
                                                  input logic [COORD_W-1:0] right);
    logic [COORD_W:0] sum;
    sum = {1'b0, left} + {1'b0, right};
    return sum[COORD_W:1];
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector with a configurable history value after reset, so a
// level held through reset can be made to not register as a press.
module edge_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= RESET_VAL;
    else        level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/player_bullet.sv
// Player projectile controller: launches one bullet from the ship centre,
// moves it up once per frame, retires it on hit or at the top, then cools down.
module player_bullet
  import player_pkg::*;
#(
  parameter logic [COORD_W-1:0] top_y_p    = SCREEN_TOP,
  parameter logic [COORD_W-1:0] start_y_p  = SHIP_TOP_Y - 10'd1,
  parameter logic [COORD_W-1:0] speed_p    = 10'd8,
  parameter logic [3:0]         cooldown_p = 4'd4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               frame_tick_i,
  input  logic               enable_i,
  input  logic               shoot_i,
  input  logic [COORD_W-1:0] pos_left_i,
  input  logic [COORD_W-1:0] pos_right_i,
  input  logic               hit_i,
  output logic               active_o,
  output logic [COORD_W-1:0] bullet_x_o,
  output logic [COORD_W-1:0] bullet_y_o,
  output logic               shot_fired_o,
  output logic               enemy_hit_o,
  output logic               miss_o,
  output logic [2:0]         state_o
);

  // Retirement threshold; one bit wider so top_y_p + speed_p cannot wrap.
  localparam logic [COORD_W:0] MISS_Y = {1'b0, top_y_p} + {1'b0, speed_p};

  bullet_state_t      state, state_n;
  logic [COORD_W-1:0] x_q, x_n;
  logic [COORD_W-1:0] y_q, y_n;
  logic [3:0]         count, count_n;
  logic               fire_n, hit_n, miss_n;
  logic               fire_q, hit_q, miss_q;
  logic               shoot_rise;

  edge_detect #(
    .RESET_VAL(1'b1)
  ) u_shoot_edge (
    .clk   (clk_i),
    .rst_n (reset_n_i),
    .level (shoot_i),
    .rise  (shoot_rise)
  );

  always_comb begin
    state_n = state;
    x_n     = x_q;
    y_n     = y_q;
    count_n = count;
    fire_n  = 1'b0;
    hit_n   = 1'b0;
    miss_n  = 1'b0;
    if (enable_i) begin
      unique case (state)
        ST_IDLE: begin
          if (shoot_rise) begin
            state_n = ST_FLYING;
            x_n     = centre_x(pos_left_i, pos_right_i);
            y_n     = start_y_p;
            fire_n  = 1'b1;
          end
        end
        ST_FLYING: begin
          if (hit_i) begin
            state_n = ST_COOLDOWN;
            count_n = cooldown_p;
            hit_n   = 1'b1;
          end else if (frame_tick_i) begin
            if ({1'b0, y_q} <= MISS_Y) begin
              state_n = ST_COOLDOWN;
              count_n = cooldown_p;
              miss_n  = 1'b1;
            end else begin
              y_n = y_q - speed_p;
            end
          end
        end
        ST_COOLDOWN: begin
          if (count == 4'd0)      state_n = ST_IDLE;
          else if (frame_tick_i)  count_n = count - 4'd1;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state  <= ST_IDLE;
      x_q    <= '0;
      y_q    <= start_y_p;
      count  <= '0;
      fire_q <= 1'b0;
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      state  <= state_n;
      x_q    <= x_n;
      y_q    <= y_n;
      count  <= count_n;
      fire_q <= fire_n;
      hit_q  <= hit_n;
      miss_q <= miss_n;
    end
  end

  assign active_o     = state[1];
  assign bullet_x_o   = x_q;
  assign bullet_y_o   = y_q;
  assign shot_fired_o = fire_q;
  assign enemy_hit_o  = hit_q;
  assign miss_o       = miss_q;
  assign state_o      = state;

endmodule

// File: tb/tb_player_bullet.sv
// Directed bench for player_bullet: launch, flight, miss, hit, cooldown,
// disable, reset and centre arithmetic.
module tb_player_bullet;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       frame_tick_i, enable_i, shoot_i, hit_i;
  logic [9:0] pos_left_i, pos_right_i;
  logic       active_o, shot_fired_o, enemy_hit_o, miss_o;
  logic [9:0] bullet_x_o, bullet_y_o;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  player_bullet dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .frame_tick_i (frame_tick_i),
    .enable_i     (enable_i),
    .shoot_i      (shoot_i),
    .pos_left_i   (pos_left_i),
    .pos_right_i  (pos_right_i),
    .hit_i        (hit_i),
    .active_o     (active_o),
    .bullet_x_o   (bullet_x_o),
    .bullet_y_o   (bullet_y_o),
    .shot_fired_o (shot_fired_o),
    .enemy_hit_o  (enemy_hit_o),
    .miss_o       (miss_o),
    .state_o      (state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_tick();
    frame_tick_i = 1'b1;
    step();
    frame_tick_i = 1'b0;
  endtask

  task automatic launch();
    shoot_i = 1'b0;
    step();
    shoot_i = 1'b1;
    step();
    shoot_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0; frame_tick_i = 0; enable_i = 0; shoot_i = 0; hit_i = 0;
    pos_left_i = 0; pos_right_i = 0;
    step(); step();
    n_checks++;
    if (state_o !== 3'b001 || active_o !== 1'b0 || bullet_x_o !== 10'd0 || bullet_y_o !== 10'd440) begin
      n_fail++;
      $display("FAIL reset_state: state=%b active=%b x=%0d y=%0d, required 001 0 0 440",
               state_o, active_o, bullet_x_o, bullet_y_o);
    end
    n_checks++;
    if ({shot_fired_o, enemy_hit_o, miss_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b required 000", {shot_fired_o, enemy_hit_o, miss_o});
    end
    reset_n_i = 1'b1;
    step();
  endtask

  task automatic test_launch();
    int fired;
    enable_i = 1; pos_left_i = 10'd100; pos_right_i = 10'd131;
    shoot_i = 0; step();
    shoot_i = 1; step();
    n_checks++;
    if (active_o !== 1'b1 || bullet_x_o !== 10'd115 || bullet_y_o !== 10'd440 || shot_fired_o !== 1'b1) begin
      n_fail++;
      $display("FAIL launch: active=%b x=%0d y=%0d fired=%b, required 1 115 440 1",
               active_o, bullet_x_o, bullet_y_o, shot_fired_o);
    end
    fired = 0;
    pos_left_i = 10'd300; pos_right_i = 10'd340;
    for (int i = 0; i < 20; i++) begin
      step();
      if (shot_fired_o) fired++;
    end
    n_checks++;
    if (fired !== 0 || state_o !== 3'b010 || bullet_x_o !== 10'd115) begin
      n_fail++;
      $display("FAIL hold_no_autofire: extra fires=%0d state=%b x=%0d, required 0 010 115",
               fired, state_o, bullet_x_o);
    end
    shoot_i = 0;
  endtask

  task automatic test_flight_miss();
    int misses;
    misses = 0;
    for (int i = 0; i < 50; i++) begin
      do_tick();
      if (miss_o) misses++;
    end
    n_checks++;
    if (bullet_y_o !== 10'd40 || misses !== 0 || state_o !== 3'b010) begin
      n_fail++;
      $display("FAIL fly_50: y=%0d misses=%0d state=%b, required 40 0 010", bullet_y_o, misses, state_o);
    end
    do_tick();
    n_checks++;
    if (miss_o !== 1'b1 || bullet_y_o !== 10'd40 || state_o !== 3'b100 || active_o !== 1'b0) begin
      n_fail++;
      $display("FAIL miss: miss=%b y=%0d state=%b active=%b, required 1 40 100 0",
               miss_o, bullet_y_o, state_o, active_o);
    end
    step();
    n_checks++;
    if (miss_o !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_pulse_width: miss=%b required 0", miss_o);
    end
    for (int i = 0; i < 3; i++) begin do_tick(); step(); end
    n_checks++;
    if (state_o !== 3'b100) begin
      n_fail++;
      $display("FAIL cooldown_3_ticks: state=%b required 100", state_o);
    end
    do_tick();
    step();
    n_checks++;
    if (state_o !== 3'b001) begin
      n_fail++;
      $display("FAIL cooldown_4_ticks: state=%b required 001", state_o);
    end
  endtask

  task automatic test_hit_priority();
    launch();
    for (int i = 0; i < 30; i++) do_tick();
    n_checks++;
    if (bullet_y_o !== 10'd200) begin
      n_fail++;
      $display("FAIL fly_30: y=%0d required 200", bullet_y_o);
    end
    hit_i = 1; frame_tick_i = 1;
    step();
    hit_i = 0; frame_tick_i = 0;
    n_checks++;
    if (enemy_hit_o !== 1'b1 || bullet_y_o !== 10'd200 || miss_o !== 1'b0 || state_o !== 3'b100) begin
      n_fail++;
      $display("FAIL hit_priority: hit=%b y=%0d miss=%b state=%b, required 1 200 0 100",
               enemy_hit_o, bullet_y_o, miss_o, state_o);
    end
  endtask

  task automatic test_cooldown_ignore();
    int fired, hits;
    fired = 0; hits = 0;
    step();
    if (enemy_hit_o) hits++;
    shoot_i = 1; step(); if (shot_fired_o) fired++;
    shoot_i = 0; hit_i = 1; step(); if (shot_fired_o) fired++; if (enemy_hit_o) hits++;
    hit_i = 0;
    for (int i = 0; i < 4; i++) begin
      do_tick(); if (shot_fired_o) fired++;
    end
    step(); step();
    n_checks++;
    if (fired !== 0 || hits !== 0 || state_o !== 3'b001) begin
      n_fail++;
      $display("FAIL cooldown_ignore: fires=%0d hits=%0d state=%b, required 0 0 001", fired, hits, state_o);
    end
  endtask

  task automatic test_disable();
    int hits;
    hits = 0;
    pos_left_i = 10'd100; pos_right_i = 10'd131;
    launch();
    for (int i = 0; i < 5; i++) do_tick();
    enable_i = 0;
    for (int i = 0; i < 10; i++) begin
      hit_i = (i == 3);
      do_tick();
      if (enemy_hit_o || miss_o) hits++;
    end
    hit_i = 0;
    n_checks++;
    if (bullet_y_o !== 10'd400 || state_o !== 3'b010 || hits !== 0) begin
      n_fail++;
      $display("FAIL disable_hold: y=%0d state=%b pulses=%0d, required 400 010 0", bullet_y_o, state_o, hits);
    end
    enable_i = 1;
    do_tick();
    n_checks++;
    if (bullet_y_o !== 10'd392) begin
      n_fail++;
      $display("FAIL resume: y=%0d required 392", bullet_y_o);
    end
  endtask

  task automatic test_reset_midflight();
    int fired;
    for (int i = 0; i < 11; i++) do_tick();
    n_checks++;
    if (bullet_y_o !== 10'd304) begin
      n_fail++;
      $display("FAIL pre_reset_y: y=%0d required 304", bullet_y_o);
    end
    @(posedge clk_i); #2;
    reset_n_i = 0;
    #1;
    n_checks++;
    if (active_o !== 1'b0 || bullet_y_o !== 10'd440 || bullet_x_o !== 10'd0 || state_o !== 3'b001 ||
        {shot_fired_o, enemy_hit_o, miss_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset: active=%b x=%0d y=%0d state=%b pulses=%b, required 0 0 440 001 000",
               active_o, bullet_x_o, bullet_y_o, state_o, {shot_fired_o, enemy_hit_o, miss_o});
    end
    shoot_i = 1;
    step();
    reset_n_i = 1;
    fired = 0;
    for (int i = 0; i < 5; i++) begin step(); if (shot_fired_o) fired++; end
    n_checks++;
    if (fired !== 0 || state_o !== 3'b001) begin
      n_fail++;
      $display("FAIL held_through_reset: fires=%0d state=%b, required 0 001", fired, state_o);
    end
    shoot_i = 0; step();
    shoot_i = 1; step();
    shoot_i = 0;
    n_checks++;
    if (shot_fired_o !== 1'b1 || active_o !== 1'b1) begin
      n_fail++;
      $display("FAIL refire_after_release: fired=%b active=%b, required 1 1", shot_fired_o, active_o);
    end
  endtask

  task automatic test_edge_centre();
    reset_n_i = 0; step();
    reset_n_i = 1;
    pos_left_i = 10'd1000; pos_right_i = 10'd1023;
    launch();
    n_checks++;
    if (bullet_x_o !== 10'd1011 || active_o !== 1'b1) begin
      n_fail++;
      $display("FAIL edge_centre: x=%0d active=%b, required 1011 1", bullet_x_o, active_o);
    end
  endtask

  initial begin
    test_reset();
    test_launch();
    test_flight_miss();
    test_hit_priority();
    test_cooldown_ignore();
    test_disable();
    test_reset_midflight();
    test_edge_centre();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
